// File: rtl/ps2_keypad_rx_pkg.sv
// Shared scan-code constants, frame FSM states and key indices for the PS/2 keypad receiver.
// Latency: n/a (declarations and a pure combinational lookup function).
// Backpressure: n/a.
package ps2_keypad_rx_pkg;

  // Frame FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // Prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Full codes as {ext, byte}
  localparam logic [8:0] SC_UP    = 9'h175;
  localparam logic [8:0] SC_DOWN  = 9'h172;
  localparam logic [8:0] SC_LEFT  = 9'h16B;
  localparam logic [8:0] SC_RIGHT = 9'h174;
  localparam logic [8:0] SC_W     = 9'h01D;
  localparam logic [8:0] SC_S     = 9'h01B;
  localparam logic [8:0] SC_A     = 9'h01C;
  localparam logic [8:0] SC_D     = 9'h023;
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_ENTER = 9'h05A;

  // Held-key bit positions
  localparam int NUM_KEYS = 10;
  localparam logic [3:0] KI_UPA   = 4'd0;
  localparam logic [3:0] KI_DNA   = 4'd1;
  localparam logic [3:0] KI_LFA   = 4'd2;
  localparam logic [3:0] KI_RTA   = 4'd3;
  localparam logic [3:0] KI_W     = 4'd4;
  localparam logic [3:0] KI_S     = 4'd5;
  localparam logic [3:0] KI_A     = 4'd6;
  localparam logic [3:0] KI_D     = 4'd7;
  localparam logic [3:0] KI_SPACE = 4'd8;
  localparam logic [3:0] KI_ENTER = 4'd9;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_sel_t;

  // Maps a {ext, byte} code to a held-key index; hit=0 for unmapped codes.
  function automatic key_sel_t key_lookup(input logic [8:0] code);
    key_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = 4'd0;
    case (code)
      SC_UP:    sel.idx = KI_UPA;
      SC_DOWN:  sel.idx = KI_DNA;
      SC_LEFT:  sel.idx = KI_LFA;
      SC_RIGHT: sel.idx = KI_RTA;
      SC_W:     sel.idx = KI_W;
      SC_S:     sel.idx = KI_S;
      SC_A:     sel.idx = KI_A;
      SC_D:     sel.idx = KI_D;
      SC_SPACE: sel.idx = KI_SPACE;
      SC_ENTER: sel.idx = KI_ENTER;
      default:  sel.hit = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronise + glitch-filter ps2_clk, deframe 11-bit frames, check parity/stop, timeout.
// Latency: byte_vld / frame_err register 1 cycle after the filtered falling edge of the stop bit.
// Backpressure: none; the keyboard cannot be stalled, so every result is a single-cycle pulse.
// Ports: i_clk, i_rst_n (async active-low), i_ps2_clk/i_ps2_data (async, idle high),
//        o_byte (last good byte), o_byte_vld (pulse), o_frame_err (pulse).
module ps2_frame_rx
  import ps2_keypad_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic              r_filt, r_filt_d;
  logic [FCNT_W-1:0] r_fcnt;
  logic              w_fe;

  frame_state_t      r_state, w_state_nxt;
  logic [7:0]        r_shift;
  logic [2:0]        r_bitcnt;
  logic              r_par;
  logic [TOUT_W-1:0] r_tout;
  logic              w_timeout;
  logic              w_shift_en, w_par_en, w_stop_chk, w_good, w_bad;
  logic [7:0]        r_byte;
  logic              r_byte_vld, r_frame_err;

  // Synchronisers and clock filter. Sync flops reset high so a reset release never fakes an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FCNT_W'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
      end
    end
  end

  assign w_fe = r_filt_d & ~r_filt;

  // An edge in the same cycle always beats the timeout.
  assign w_timeout = (r_state != ST_IDLE) && !w_fe &&
                     (r_tout == TOUT_W'(TIMEOUT_CYCLES - 1));

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else if (w_fe) begin
      case (r_state)
        ST_IDLE:   if (!r_dat_s2) w_state_nxt = ST_DATA;  // data=1 is a spurious start
        ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_stop_chk = 1'b0;
    case (r_state)
      ST_DATA:   w_shift_en = w_fe;
      ST_PARITY: w_par_en   = w_fe;
      ST_STOP:   w_stop_chk = w_fe;
      default:   ;
    endcase
  end

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  assign w_good = w_stop_chk && r_dat_s2 && (^{r_shift, r_par});
  assign w_bad  = (w_stop_chk && !w_good) || w_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_par       <= 1'b0;
      r_tout      <= '0;
      r_byte      <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_bitcnt <= '0;
      else if (w_shift_en)    r_bitcnt <= r_bitcnt + 3'd1;
      if (w_shift_en) r_shift <= {r_dat_s2, r_shift[7:1]};  // LSB arrives first
      if (w_par_en)   r_par   <= r_dat_s2;
      if (r_state == ST_IDLE || w_fe) r_tout <= '0;
      else                            r_tout <= r_tout + TOUT_W'(1);
      if (w_good) r_byte <= r_shift;
      r_byte_vld  <= w_good;
      r_frame_err <= w_bad;
    end
  end

  assign o_byte      = r_byte;
  assign o_byte_vld  = r_byte_vld;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver + scan-code decoder producing level-held player keys (arrows/WASD, Space, Enter).
// Latency: code_valid 1 cycle after the stop-bit filtered edge; held keys update at the end of that cycle.
// Backpressure: none; results are pulses and held levels, nothing waits on a consumer.
// Ports: i_clk (100 MHz), i_rst_n (async active-low), i_ps2_clk/i_ps2_data (async),
//        o_key_* held levels, o_scan_code last good byte, o_code_valid / o_frame_err pulses.
module ps2_keypad_rx
  import ps2_keypad_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_key_up,
  output logic       o_key_down,
  output logic       o_key_left,
  output logic       o_key_right,
  output logic       o_key_attack,
  output logic       o_key_done,
  output logic [7:0] o_scan_code,
  output logic       o_code_valid,
  output logic       o_frame_err
);

  logic [7:0]          w_byte;
  logic                w_byte_vld;
  logic                w_frame_err;
  logic [NUM_KEYS-1:0] r_held;
  logic                r_ext, r_brk;
  key_sel_t            w_sel;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_byte      (w_byte),
    .o_byte_vld  (w_byte_vld),
    .o_frame_err (w_frame_err)
  );

  assign w_sel = key_lookup({r_ext, w_byte});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held <= '0;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
    end else if (w_byte_vld) begin
      if (w_byte == SC_E0) begin
        r_ext <= 1'b1;
      end else if (w_byte == SC_F0) begin
        r_brk <= 1'b1;
      end else begin
        // Typematic repeats rewrite the same value, so held outputs never glitch.
        if (w_sel.hit) r_held[w_sel.idx] <= ~r_brk;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end else if (w_frame_err) begin
      // A lost byte may have been the rest of a prefixed code; drop the prefixes with it.
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end
  end

  assign o_key_up     = r_held[KI_UPA] | r_held[KI_W];
  assign o_key_down   = r_held[KI_DNA] | r_held[KI_S];
  assign o_key_left   = r_held[KI_LFA] | r_held[KI_A];
  assign o_key_right  = r_held[KI_RTA] | r_held[KI_D];
  assign o_key_attack = r_held[KI_SPACE];
  assign o_key_done   = r_held[KI_ENTER];
  assign o_scan_code  = w_byte;
  assign o_code_valid = w_byte_vld;
  assign o_frame_err  = w_frame_err;

endmodule
